// File: rtl/bar_pos_ctrl.sv
// rtl/bar_pos_ctrl.sv - paddle Y position command decoder with frame-synchronous commit
module bar_pos_ctrl #(
  parameter int BAR_H  = 60,
  parameter int Y_INIT = 210
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        clk_en,
  input  logic [31:0] dataa,
  input  logic        i_frame_end,
  output logic        done,
  output logic [31:0] result,
  output logic [9:0]  y_bar1,
  output logic [9:0]  y_bar2,
  output logic        busy
);

  localparam logic [9:0] Y_MAX = 10'(480 - BAR_H);
  localparam logic [9:0] Y_RST = 10'(Y_INIT);

  typedef enum logic [1:0] {IDLE, RESP, WAIT_FRM} state_t;

  state_t     state;
  logic [9:0] sh1;
  logic [9:0] sh2;
  logic       p1;
  logic       p2;

  // command word fields; upper bits carry no meaning
  logic [9:0] cmd_y;
  logic       cmd_bar2;
  logic       cmd_read;
  logic       cmd_wait;
  logic       unused_dataa;
  logic [9:0] y_clamped;

  assign cmd_y        = dataa[9:0];
  assign cmd_bar2     = dataa[10];
  assign cmd_read     = dataa[11];
  assign cmd_wait     = dataa[12];
  assign unused_dataa = ^dataa[31:13];

  // only an upper clamp: the bar must stay fully on screen at the bottom
  assign y_clamped = (cmd_y > Y_MAX) ? Y_MAX : cmd_y;

  // instruction FSM, shadow registers and frame-boundary commit
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
      y_bar1 <= Y_RST;
      y_bar2 <= Y_RST;
      sh1    <= Y_RST;
      sh2    <= Y_RST;
      p1     <= 1'b0;
      p2     <= 1'b0;
    end else begin
      done <= 1'b0;

      // commit uses the shadow/pending state from before this edge; a write
      // accepted on the same edge re-sets its flag below and waits a frame
      if (i_frame_end) begin
        if (p1) begin
          y_bar1 <= sh1;
          p1     <= 1'b0;
        end
        if (p2) begin
          y_bar2 <= sh2;
          p2     <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (clk_en) begin
            busy <= 1'b1;
            if (cmd_read) begin
              result <= {6'b0, y_bar2, 6'b0, y_bar1};
              state  <= RESP;
            end else begin
              result <= {22'b0, y_clamped};
              if (cmd_bar2) begin
                sh2 <= y_clamped;
                p2  <= 1'b1;
              end else begin
                sh1 <= y_clamped;
                p1  <= 1'b1;
              end
              state <= cmd_wait ? WAIT_FRM : RESP;
            end
          end
        end
        RESP: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        WAIT_FRM: begin
          if (i_frame_end) begin
            state <= RESP;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bar_pos_ctrl.sv
// tb/tb_bar_pos_ctrl.sv - directed self-checking bench for bar_pos_ctrl
module tb_bar_pos_ctrl;

  logic        CLK = 1'b0;
  logic        RST_BTN = 1'b0;
  logic        clk_en = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic        i_frame_end = 1'b0;
  logic        done;
  logic [31:0] result;
  logic [9:0]  y_bar1;
  logic [9:0]  y_bar2;
  logic        busy;

  int total = 0;
  int bad = 0;

  bar_pos_ctrl #(.BAR_H(60), .Y_INIT(210)) dut (
    .CLK(CLK),
    .RST_BTN(RST_BTN),
    .clk_en(clk_en),
    .dataa(dataa),
    .i_frame_end(i_frame_end),
    .done(done),
    .result(result),
    .y_bar1(y_bar1),
    .y_bar2(y_bar2),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // present a command for exactly one rising edge; returns just after that edge
  task automatic pulse_cmd(input logic [31:0] d);
    @(negedge CLK);
    clk_en = 1'b1;
    dataa  = d;
    @(negedge CLK);
    clk_en = 1'b0;
  endtask

  // one-cycle frame-end pulse; returns just after the commit edge
  task automatic frame_pulse();
    @(negedge CLK);
    i_frame_end = 1'b1;
    @(negedge CLK);
    i_frame_end = 1'b0;
  endtask

  // normal instruction: done and result one cycle after the accept edge, then done drops
  task automatic cmd_expect(input string tag, input logic [31:0] d, input logic [31:0] exp_res);
    pulse_cmd(d);
    check({tag, "_done_early"}, {31'b0, done}, 32'd0);
    @(negedge CLK);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_result"}, result, exp_res);
    @(negedge CLK);
    check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    logic saw_bad;

    // power-on reset
    repeat (3) @(negedge CLK);
    check("rst_y1", {22'b0, y_bar1}, 32'd210);
    check("rst_y2", {22'b0, y_bar2}, 32'd210);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    RST_BTN = 1'b1;

    // reset while a wait-mode write of bar2 is in flight
    pulse_cmd(32'h0000_1405);
    @(negedge CLK);
    check("midwait_busy", {31'b0, busy}, 32'd1);
    #2 RST_BTN = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_y1", {22'b0, y_bar1}, 32'd210);
    check("midrst_y2", {22'b0, y_bar2}, 32'd210);
    saw_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) saw_bad = 1'b1;
    end
    RST_BTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (done !== 1'b0) saw_bad = 1'b1;
    end
    check("midrst_no_done", {31'b0, saw_bad}, 32'd0);
    frame_pulse();
    check("midrst_dropped_y2", {22'b0, y_bar2}, 32'd210);
    cmd_expect("rd_after_rst", 32'h0000_0800, 32'h00D2_00D2);

    // basic write and commit of bar1
    cmd_expect("wr_b1_100", 32'h0000_0064, 32'd100);
    check("pre_commit_y1", {22'b0, y_bar1}, 32'd210);
    frame_pulse();
    check("commit_y1", {22'b0, y_bar1}, 32'd100);
    check("commit_y2_kept", {22'b0, y_bar2}, 32'd210);

    // clamp then last write wins
    cmd_expect("wr_b2_clamp", 32'h0000_07E8, 32'd420);
    cmd_expect("wr_b2_300", 32'h0000_052C, 32'd300);
    check("pre_commit_y2", {22'b0, y_bar2}, 32'd210);
    frame_pulse();
    check("lastwins_y2", {22'b0, y_bar2}, 32'd300);
    check("lastwins_y1", {22'b0, y_bar1}, 32'd100);

    // write colliding with frame end
    cmd_expect("wr_b1_80", 32'h0000_0050, 32'd80);
    @(negedge CLK);
    clk_en = 1'b1;
    dataa = 32'h0000_0032;
    i_frame_end = 1'b1;
    @(negedge CLK);
    clk_en = 1'b0;
    i_frame_end = 1'b0;
    check("coll_y1_old", {22'b0, y_bar1}, 32'd80);
    @(negedge CLK);
    check("coll_done", {31'b0, done}, 32'd1);
    check("coll_result", result, 32'd50);
    frame_pulse();
    check("coll_y1_next", {22'b0, y_bar1}, 32'd50);

    // wait-mode write of bar2 with a long gap to frame end
    pulse_cmd(32'h0000_14C8);
    check("wait_result_cap", result, 32'd200);
    saw_bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        clk_en = 1'b1;
        dataa = 32'h0000_0064;
      end else begin
        clk_en = 1'b0;
      end
      @(negedge CLK);
      if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd200) saw_bad = 1'b1;
    end
    clk_en = 1'b0;
    check("wait_stalled", {31'b0, saw_bad}, 32'd0);
    frame_pulse();
    check("wait_commit_y2", {22'b0, y_bar2}, 32'd200);
    check("wait_done_not_yet", {31'b0, done}, 32'd0);
    @(negedge CLK);
    check("wait_done", {31'b0, done}, 32'd1);
    check("wait_result", result, 32'd200);
    @(negedge CLK);
    check("wait_done_drop", {31'b0, done}, 32'd0);
    check("wait_busy_clear", {31'b0, busy}, 32'd0);
    frame_pulse();
    check("wait_ignored_y1", {22'b0, y_bar1}, 32'd50);

    // command held into the done cycle is ignored
    @(negedge CLK);
    clk_en = 1'b1;
    dataa = 32'h0000_0064;
    @(negedge CLK);
    dataa = 32'h0000_0007;
    @(negedge CLK);
    clk_en = 1'b0;
    check("held_done", {31'b0, done}, 32'd1);
    check("held_result", result, 32'd100);
    @(negedge CLK);
    check("held_done_drop", {31'b0, done}, 32'd0);
    frame_pulse();
    check("held_y1", {22'b0, y_bar1}, 32'd100);

    // read back after commit of bar1=100, bar2=420
    cmd_expect("wr_b2_420", 32'h0000_07E8, 32'd420);
    frame_pulse();
    check("rb_y2", {22'b0, y_bar2}, 32'd420);
    cmd_expect("readback", 32'h0000_0800, 32'h01A4_0064);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bar_pos_ctrl.md
# bar_pos_ctrl

Upstream stage of the VGA paddle renderer: accepts bar-position commands from the Nios II custom-instruction interface and produces the two registered bar Y coordinates consumed by the two bar drawers. Writes are held in shadow registers and committed only at the frame boundary, so a bar never tears mid-frame. Supports an optional wait mode that stalls the instruction until the commit has taken effect.

## Interface
Parameters:
- BAR_H, 60, bar height in lines; Y_MAX = 480 - BAR_H (420 at default).
- Y_INIT, 210, reset position of both bars.

Ports:
- CLK  in  1  system clock (50 MHz).
- RST_BTN  in  1  reset, asynchronous, active-low.
- clk_en  in  1  custom-instruction start, single-cycle pulse.
- dataa  in  32  command word.
- i_frame_end  in  1  single-cycle pulse from the timing generator at start of vertical blanking.
- done  out  1  custom-instruction completion, single-cycle pulse.
- result  out  32  instruction result.
- y_bar1  out  10  committed Y of bar 1.
- y_bar2  out  10  committed Y of bar 2.
- busy  out  1  high while an instruction is in flight.

## Operation
- Command decode on an accepted clk_en:
  - dataa[9:0] is the Y value.
  - dataa[10] selects the bar: 0 = bar1, 1 = bar2.
  - dataa[11] selects the operation: 0 = write, 1 = read.
  - dataa[12] is wait mode and applies to writes only.
  - dataa[31:13] is ignored.
- Clamp: written Y is forced to Y_MAX if Y > Y_MAX (unsigned 10-bit compare). No lower clamp.
- Write:
  - Clamped value goes into shadow register sh1 or sh2, and the matching pending flag p1 or p2 is set.
  - result = {22'b0, clamped Y}.
- Read: result = {6'b0, y_bar2, 6'b0, y_bar1}, sampled at the accept edge. Shadows are untouched.
- Commit: on i_frame_end, every bar whose pending flag is set copies its shadow to the output register y_barN, and that flag clears. Bars without a pending flag keep their value.
- Two writes to the same bar before a commit: the last one wins.
- FSM states:
  - IDLE: accept clk_en. Go to RESP, or to WAIT_FRM for a wait-mode write.
  - RESP: assert done, return to IDLE.
  - WAIT_FRM: hold until i_frame_end, then assert done that same cycle's next edge and return to IDLE.
- busy = (state != IDLE).
- clk_en while busy is ignored: no capture, no shadow change.
- Simultaneous clk_en write and i_frame_end in IDLE:
  - The commit uses the old shadow/pending state.
  - The new write lands in the shadow with its pending flag set and commits at the next frame.
  - A wait-mode write in this case waits for the next i_frame_end.
- Reset (asynchronous, anytime, including mid-instruction):
  - y_bar1 = y_bar2 = Y_INIT.
  - sh1 = sh2 = Y_INIT; p1 = p2 = 0.
  - done = 0, result = 0, busy = 0, state IDLE.
  - Any in-flight instruction is dropped and no done is issued.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Normal write/read: clk_en sampled at edge N; done and result valid for exactly one cycle after edge N+1. Latency is 1 cycle.
- Commit: i_frame_end sampled at edge F; y_barN shows the new value after edge F.
- Wait-mode write: done pulses one cycle, registered on the edge after the i_frame_end edge that commits the write. result is held stable from capture through done.
- result holds its last value between instructions. done is 0 except for the one-cycle pulse.
- clk_en at edge N+1 (the cycle done is high) is ignored. The next accepted clk_en is at edge N+2 at the earliest.

## Test plan
- Reset: assert RST_BTN=0 mid-WAIT_FRM.
  - Required: y_bar1=y_bar2=210, done never pulses, busy=0.
  - After release, a read returns 0x00D2_00D2.
- Basic write/commit: write bar1 Y=100 (dataa=0x064).
  - Required: done at N+1 with result=100; y_bar1 stays 210 until i_frame_end, then becomes 100; y_bar2 stays 210.
- Clamp and last-wins: write bar2 Y=1000 (dataa=0x7E8), then bar2 Y=300 (dataa=0x52C), both before one frame end.
  - Required: first result = 420; after commit y_bar2 = 300.
- Collision: write bar1 Y=50 on the same edge as i_frame_end, with an earlier pending bar1 write of 80.
  - Required: y_bar1 = 80 after this frame and 50 after the next frame.
- Wait mode: write bar2 Y=200 with dataa[12]=1, and i_frame_end arrives 1000 cycles later.
  - Required: busy stays high, and a clk_en issued during the wait is ignored.
  - done pulses on the edge after the commit, result = 200, y_bar2 = 200.
- Read back: after committing bar1 = 100 and bar2 = 420, issue a read (dataa=0x800).
  - Required: result = 0x01A4_0064, with done at N+1.
